// File: rtl/pipeline_fetch_stage_pkg.sv
// Shared fetch-stage constants and the next-PC source selector.
// The exception vectors and NOP are also used by the ID and exception logic.
package pipeline_fetch_stage_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0008;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam int          ROM_AW    = 7;

    // One entry per row of the per-edge priority table (reset handled separately).
    typedef enum logic [2:0] {
        SEL_BRANCH,
        SEL_ILLOP,
        SEL_IRQ,
        SEL_STALL,
        SEL_JUMP,
        SEL_SEQ
    } pc_sel_e;

    // Sequential successor: bit31 (supervisor) is carried, never set by the add.
    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pipeline_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes the contents.
// Flush outranks hold so redirects can squash a stalled fetch.
module pipeline_if_id_reg
    import pipeline_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_instr    <= NOP;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/pipeline_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC priority mux,
// ROM address decode, IF/ID register and a count of valid fetched instructions.
module pipeline_fetch_stage
    import pipeline_fetch_stage_pkg::*;
#(
    parameter logic [31:0] P_RESET_VEC = RESET_VEC,
    parameter logic [31:0] P_IRQ_VEC   = IRQ_VEC,
    parameter logic [31:0] P_ILLOP_VEC = ILLOP_VEC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_branch_taken,
    input  logic [31:0]       ex_branch_target,
    input  logic              id_jump,
    input  logic [31:0]       id_jump_target,
    input  logic              id_illop,
    input  logic              irq_req,
    input  logic [31:0]       rom_instr,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_enable,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [31:0]       fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    pc_sel_e     w_sel;
    logic        w_flush;
    logic        w_hold;

    assign w_pc_plus4 = pcPlus4(r_pc);

    // Redirects from later stages beat the load-use stall; a user-mode PC is
    // the only thing that lets a pending interrupt in.
    always_comb begin
        w_sel = SEL_SEQ;
        if (ex_branch_taken)
            w_sel = SEL_BRANCH;
        else if (id_illop)
            w_sel = SEL_ILLOP;
        else if (irq_req && !r_pc[31])
            w_sel = SEL_IRQ;
        else if (stall)
            w_sel = SEL_STALL;
        else if (id_jump)
            w_sel = SEL_JUMP;
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (w_sel)
            SEL_BRANCH: w_pc_next = ex_branch_target;
            SEL_ILLOP:  w_pc_next = P_ILLOP_VEC;
            SEL_IRQ:    w_pc_next = P_IRQ_VEC;
            SEL_STALL:  w_pc_next = r_pc;
            SEL_JUMP:   w_pc_next = id_jump_target;
            default:    w_pc_next = w_pc_plus4;
        endcase
    end

    assign w_flush = (w_sel == SEL_BRANCH) || (w_sel == SEL_ILLOP) ||
                     (w_sel == SEL_IRQ)    || (w_sel == SEL_JUMP);
    assign w_hold  = (w_sel == SEL_STALL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= P_RESET_VEC;
            r_fetch_count <= 32'h0;
        end else begin
            r_pc <= w_pc_next;
            if (w_sel == SEL_SEQ)
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    pipeline_if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .i_hold     (w_hold),
        .i_flush    (w_flush),
        .i_instr    (rom_instr),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (if_id_instr),
        .o_pc_plus4 (if_id_pc_plus4),
        .o_valid    (if_id_valid)
    );

    // ROM covers pc[30:9]==0 in both user and supervisor halves.
    assign rom_addr    = r_pc[ROM_AW+1:2];
    assign rom_enable  = (r_pc[30:9] == 22'h0);
    assign pc          = r_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Directed test of pipeline_fetch_stage against hand-computed expectations.
// The ROM model returns 32'h2400_0000 | word_address when enabled, else 0.
module tb_pipeline_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        id_illop;
    logic        irq_req;
    logic [31:0] rom_instr;
    logic [6:0]  rom_addr;
    logic        rom_enable;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    assign rom_instr = rom_enable ? (32'h2400_0000 | {25'd0, rom_addr}) : 32'h0;

    pipeline_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .id_illop         (id_illop),
        .irq_req          (irq_req),
        .rom_instr        (rom_instr),
        .rom_addr         (rom_addr),
        .rom_enable       (rom_enable),
        .pc               (pc),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .fetch_count      (fetch_count)
    );

    // Drives one cycle's control inputs, then lets one rising edge pass and
    // settles 1 time unit after it so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic rst, input logic br, input logic [31:0] brTgt,
                                 input logic ill, input logic irq, input logic stl,
                                 input logic jmp, input logic [31:0] jmpTgt);
        reset            = rst;
        ex_branch_taken  = br;
        ex_branch_target = brTgt;
        id_illop         = ill;
        irq_req          = irq;
        stall            = stl;
        id_jump          = jmp;
        id_jump_target   = jmpTgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Full visible state after an edge.
    task automatic checkState(input string tag, input logic [31:0] expPc,
                              input logic [31:0] expInstr, input logic [31:0] expPlus4,
                              input logic expValid, input logic [31:0] expCount);
        checkOutput({tag, ".pc"},    pc,                 expPc);
        checkOutput({tag, ".instr"}, if_id_instr,        expInstr);
        checkOutput({tag, ".plus4"}, if_id_pc_plus4,     expPlus4);
        checkOutput({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, expValid});
        checkOutput({tag, ".count"}, fetch_count,        expCount);
    endtask

    initial begin
        $display("[TB] starting pipeline_fetch_stage directed test");

        // Reset and release
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("reset", 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        checkOutput("reset.romAddr", {25'd0, rom_addr}, 32'd0);
        checkOutput("reset.romEn", {31'd0, rom_enable}, 32'd1);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("first", 32'h8000_0004, 32'h2400_0000, 32'h8000_0004, 1, 1);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("second", 32'h8000_0008, 32'h2400_0001, 32'h8000_0008, 1, 2);

        // Two stalled cycles hold everything, then fetch resumes at the held pc
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        checkState("stall1", 32'h8000_0008, 32'h2400_0001, 32'h8000_0008, 1, 2);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        checkState("stall2", 32'h8000_0008, 32'h2400_0001, 32'h8000_0008, 1, 2);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("resume", 32'h8000_000C, 32'h2400_0002, 32'h8000_000C, 1, 3);

        // Branch beats stall and jump
        applyStimulus(0, 1, 32'h0000_0040, 0, 0, 1, 1, 32'h0000_0080);
        checkState("branch", 32'h0000_0040, 32'h0, 32'h0, 0, 3);
        checkOutput("branch.romAddr", {25'd0, rom_addr}, 32'd16);

        // Interrupt taken from user mode, ignored in supervisor mode
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 32'h0000_0100);
        checkState("jumpUser", 32'h0000_0100, 32'h0, 32'h0, 0, 3);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
        checkState("irqTaken", 32'h8000_0004, 32'h0, 32'h0, 0, 3);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0010);
        checkState("irqSupJump", 32'h8000_0010, 32'h0, 32'h0, 0, 3);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
        checkState("irqIgnored", 32'h8000_0014, 32'h2400_0004, 32'h8000_0014, 1, 4);
        checkOutput("irqIgnored.romAddr", {25'd0, rom_addr}, 32'd5);

        // Illegal op beats jump
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 1, 32'h0000_0080);
        checkState("illop", 32'h8000_0008, 32'h0, 32'h0, 0, 4);

        // Outside the ROM: a counted nop
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 32'h0000_0200);
        checkState("jumpOut", 32'h0000_0200, 32'h0, 32'h0, 0, 4);
        checkOutput("jumpOut.romEn", {31'd0, rom_enable}, 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("outNop", 32'h0000_0204, 32'h0, 32'h0000_0204, 1, 5);

        // 31-bit wrap keeps bit31 in both modes
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 32'h7FFF_FFFC);
        checkState("jumpUserTop", 32'h7FFF_FFFC, 32'h0, 32'h0, 0, 5);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("wrapUser", 32'h0000_0000, 32'h0, 32'h0000_0000, 1, 6);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        checkState("jumpSupTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 6);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("wrapSup", 32'h8000_0000, 32'h0, 32'h8000_0000, 1, 7);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("afterWrap", 32'h8000_0004, 32'h2400_0000, 32'h8000_0004, 1, 8);

        // Mid-run reset wins over a simultaneous branch
        applyStimulus(1, 1, 32'h0000_0040, 0, 0, 0, 0, 32'h0);
        checkState("midReset", 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        checkState("postReset", 32'h8000_0004, 32'h2400_0000, 32'h8000_0004, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
